// File: rtl/spi_reg_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_pkg
// Shared types and helpers for the SPI register bank.
//   state_t      : frame-handling state machine encoding
//   RW_WRITE/READ: value of the leading frame bit for each access type
//   calc_frame_w : total frame length in bits for a given address/data width
// ---------------------------------------------------------------------------
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DATA    = 3'd2,
    COMMIT  = 3'd3,
    WAIT_CS = 3'd4
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // One R/W bit, then the address field, then the data field.
  function automatic int calc_frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchroniser for an asynchronous pin followed by one history flop
// used to detect edges of the synchronised level.
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   i_async in  asynchronous input pin
//   o_sync  out synchronised level
//   o_rise  out one-cycle pulse on a 0->1 transition of o_sync
//   o_fall  out one-cycle pulse on a 1->0 transition of o_sync
// RESET_LVL is the idle level of the pin, so leaving reset with the pin at
// rest produces no edge.
// ---------------------------------------------------------------------------
module spi_sync_edge #(
  parameter logic RESET_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchroniser chain plus history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_LVL;
      r_sync <= RESET_LVL;
      r_prev <= RESET_LVL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_reg_bank.sv
// ---------------------------------------------------------------------------
// spi_reg_bank
// SPI mode-0 (MSB first) peripheral exposing NUM_REGS writable/readable
// registers. All pins are oversampled in the clk domain.
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   cs_n      in  chip select, active low (asynchronous)
//   sclk      in  SPI clock (asynchronous, sampled as data)
//   copi      in  serial data from controller
//   cipo      out serial read data to controller
//   cipo_oe   out pad enable, high while synchronised cs_n is low
//   regs      out flattened registers, register k at [k*DATA_W +: DATA_W]
//   wr_strobe out one-cycle pulse on bit k when register k is written
//   frame_err out one-cycle pulse when a frame is aborted by cs_n rising
// Frame: R/W bit (1 = write), ADDR_W address bits, DATA_W data bits.
// ---------------------------------------------------------------------------
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                NUM_REGS  = 5,
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cs_n,
  input  logic                       sclk,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int FRAME_W = calc_frame_w(ADDR_W, DATA_W);
  localparam int CMD_W   = 1 + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  // ---------------- pin synchronisation ----------------
  logic w_sclk_sync_unused;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_sync;
  logic w_cs_rise;
  logic w_cs_fall;
  logic r_copi_meta;
  logic r_copi_sync;

  spi_sync_edge #(.RESET_LVL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (sclk),
    .o_sync  (w_sclk_sync_unused),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.RESET_LVL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (cs_n),
    .o_sync  (w_cs_sync),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // Two-flop synchroniser for copi; it only ever needs a level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_copi_meta <= 1'b0;
      r_copi_sync <= 1'b0;
    end else begin
      r_copi_meta <= copi;
      r_copi_sync <= r_copi_meta;
    end
  end

  // ---------------- frame state ----------------
  state_t              r_state;
  state_t              w_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt;
  logic [FRAME_W-2:0]  r_rx;
  logic [FRAME_W-2:0]  w_rx;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   w_tx;
  logic                r_rd;
  logic                w_rd;
  logic                w_commit;
  logic                w_abort;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_strobe;
  logic                r_err;
  logic                r_cipo;
  logic                r_cipo_oe;

  // Received bits including the one arriving on the current sclk rise.
  logic [FRAME_W-1:0]  w_rx_shift;
  logic                w_cmd_rw;
  logic [ADDR_W-1:0]   w_cmd_addr;
  logic                w_frame_rw;
  logic [ADDR_W-1:0]   w_frame_addr;
  logic [DATA_W-1:0]   w_frame_data;
  logic [DATA_W-1:0]   w_rd_data;

  assign w_rx_shift   = {r_rx, r_copi_sync};
  // When the command completes, the command occupies the low CMD_W bits.
  assign w_cmd_rw     = w_rx_shift[ADDR_W];
  assign w_cmd_addr   = w_rx_shift[ADDR_W-1:0];
  // When the frame completes, it occupies the whole shifter.
  assign w_frame_rw   = w_rx_shift[FRAME_W-1];
  assign w_frame_addr = w_rx_shift[DATA_W +: ADDR_W];
  assign w_frame_data = w_rx_shift[DATA_W-1:0];

  // Read-data mux; addresses with no register read as zero.
  always_comb begin
    w_rd_data = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_cmd_addr == ADDR_W'(k)) begin
        w_rd_data = r_regs[k];
      end else begin
        w_rd_data = w_rd_data;
      end
    end
  end

  // Next-state, bit counting and shifter control.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_rx     = r_rx;
    w_tx     = r_tx;
    w_rd     = r_rd;
    w_commit = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      IDLE: begin
        // An sclk rise coinciding with the cs_n fall is not counted.
        if (w_cs_fall) begin
          w_state = CMD;
          w_cnt   = {CNT_W{1'b0}};
          w_rx    = {(FRAME_W-1){1'b0}};
          w_tx    = {DATA_W{1'b0}};
          w_rd    = 1'b0;
        end else begin
          w_state = IDLE;
        end
      end
      CMD: begin
        if (w_cs_rise) begin
          w_state = IDLE;
          w_abort = 1'b1;
        end else if (w_sclk_rise) begin
          w_rx  = w_rx_shift[FRAME_W-2:0];
          w_cnt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(CMD_W - 1)) begin
            w_state = DATA;
            w_rd    = (w_cmd_rw == RW_READ);
            w_tx    = (w_cmd_rw == RW_READ) ? w_rd_data : {DATA_W{1'b0}};
          end else begin
            w_state = CMD;
          end
        end else begin
          w_state = CMD;
        end
      end
      DATA: begin
        // The final bit wins over a simultaneous cs_n rise.
        if (w_sclk_rise && (r_cnt == CNT_W'(FRAME_W - 1))) begin
          w_rx     = w_rx_shift[FRAME_W-2:0];
          w_cnt    = r_cnt + CNT_W'(1);
          w_state  = COMMIT;
          w_commit = 1'b1;
        end else if (w_cs_rise) begin
          w_state = IDLE;
          w_abort = 1'b1;
        end else if (w_sclk_rise) begin
          w_rx  = w_rx_shift[FRAME_W-2:0];
          w_cnt = r_cnt + CNT_W'(1);
        end else if (w_sclk_fall && (r_cnt > CNT_W'(CMD_W))) begin
          // The fall closing the last command bit must keep the MSB on cipo
          // for the first data rise, so shifting starts after a data bit.
          w_tx = {r_tx[DATA_W-2:0], 1'b0};
        end else begin
          w_state = DATA;
        end
      end
      COMMIT: begin
        w_state = WAIT_CS;
      end
      WAIT_CS: begin
        // Level test so a cs_n rise that landed during COMMIT is not missed.
        if (w_cs_sync) begin
          w_state = IDLE;
        end else begin
          w_state = WAIT_CS;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // FSM, shifters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_rx      <= {(FRAME_W-1){1'b0}};
      r_tx      <= {DATA_W{1'b0}};
      r_rd      <= 1'b0;
      r_err     <= 1'b0;
      r_cipo    <= 1'b0;
      r_cipo_oe <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_rx      <= w_rx;
      r_tx      <= w_tx;
      r_rd      <= w_rd;
      r_err     <= w_abort;
      r_cipo    <= ((w_state == DATA) && w_rd) ? w_tx[DATA_W-1] : 1'b0;
      r_cipo_oe <= ~w_cs_sync;
    end
  end

  // Register file and strobes, loaded on the edge that enters COMMIT so both
  // are visible during the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= RESET_VAL;
      end
      r_strobe <= {NUM_REGS{1'b0}};
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_commit && (w_frame_rw == RW_WRITE) && (w_frame_addr == ADDR_W'(k))) begin
          r_regs[k]   <= w_frame_data;
          r_strobe[k] <= 1'b1;
        end else begin
          r_strobe[k] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign wr_strobe = r_strobe;
  assign frame_err = r_err;
  assign cipo      = r_cipo;
  assign cipo_oe   = r_cipo_oe;

endmodule

// File: tb/tb_spi_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_bank
// Drives SPI frames bit by bit and compares the register bank, strobes,
// frame errors and read-back data against a register-array model.
// ---------------------------------------------------------------------------
module tb_spi_reg_bank;

  localparam int NR = 5;
  localparam int AW = 7;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cs_n;
  logic            sclk;
  logic            copi;
  logic            cipo;
  logic            cipo_oe;
  logic [NR*DW-1:0] regs;
  logic [NR-1:0]   wr_strobe;
  logic            frame_err;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_regs [NR];

  int           strobe_cycles = 0;
  int           multi_strobe  = 0;
  int           err_cycles    = 0;
  logic [NR-1:0] last_mask    = '0;
  int           half          = 5;

  spi_reg_bank #(
    .NUM_REGS  (NR),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .copi      (copi),
    .cipo      (cipo),
    .cipo_oe   (cipo_oe),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts strobe and error cycles.
  always @(negedge clk) begin
    if (wr_strobe != '0) begin
      strobe_cycles++;
      last_mask = wr_strobe;
      if ($countones(wr_strobe) != 1) multi_strobe++;
    end
    if (frame_err) err_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1);
  end

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = exp_regs[k];
    return v;
  endfunction

  // Model of a frame: only a complete write to an existing register changes state.
  task automatic model_frame(input logic [15:0] word, input int nbits);
    if (nbits >= 16 && word[15] == 1'b1 && int'(word[14:8]) < NR)
      exp_regs[int'(word[14:8])] = word[7:0];
  endtask

  function automatic logic [DW-1:0] model_read(input int addr);
    return (addr < NR) ? exp_regs[addr] : 8'h00;
  endfunction

  task automatic spi_bit(input logic b, output logic seen);
    copi = b;
    repeat (half) @(negedge clk);
    seen = cipo;
    sclk = 1'b1;
    repeat (half) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Sends nbits (bits past 16 are random junk); returns cipo seen at data rises.
  task automatic run_frame(input logic [15:0] word, input int nbits, input bit end_cs,
                           input int gap, output logic [7:0] rd);
    logic s;
    logic b;
    rd = 8'h00;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) b = word[15-i];
      else b = 1'($urandom);
      spi_bit(b, s);
      if (i >= 8 && i < 16) rd = {rd[6:0], s};
    end
    repeat (half) @(negedge clk);
    if (end_cs) begin
      cs_n = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; copi = 1'b0;
    for (int k = 0; k < NR; k++) exp_regs[k] = 8'h00;
    repeat (4) @(negedge clk);
    checks++; if (regs !== '0) begin failures++; $display("FAIL reset_regs got=%h want=0", regs); end
    checks++; if (wr_strobe !== '0) begin failures++; $display("FAIL reset_strobe got=%b want=0", wr_strobe); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", frame_err); end
    checks++; if (cipo !== 1'b0) begin failures++; $display("FAIL reset_cipo got=%b want=0", cipo); end
    checks++; if (cipo_oe !== 1'b0) begin failures++; $display("FAIL reset_cipo_oe got=%b want=0", cipo_oe); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (cipo_oe !== 1'b0) begin failures++; $display("FAIL idle_cipo_oe got=%b want=0", cipo_oe); end
  endtask

  task automatic test_write();
    logic [7:0] rd;
    int s0 = strobe_cycles;
    int e0 = err_cycles;
    run_frame(16'h82A5, 16, 1'b1, 8, rd);
    model_frame(16'h82A5, 16);
    checks++; if (regs[2*DW +: DW] !== 8'hA5) begin failures++; $display("FAIL write_reg2 got=%h want=a5", regs[2*DW +: DW]); end
    checks++; if (regs !== model_vec()) begin failures++; $display("FAIL write_regs got=%h want=%h", regs, model_vec()); end
    checks++; if (strobe_cycles - s0 !== 1) begin failures++; $display("FAIL write_strobe_cycles got=%0d want=1", strobe_cycles - s0); end
    checks++; if (last_mask !== 5'b00100) begin failures++; $display("FAIL write_strobe_mask got=%b want=00100", last_mask); end
    checks++; if (err_cycles - e0 !== 0) begin failures++; $display("FAIL write_err got=%0d want=0", err_cycles - e0); end
  endtask

  task automatic test_read();
    logic [7:0] rd;
    int s0 = strobe_cycles;
    run_frame(16'h0200, 16, 1'b1, 8, rd);
    checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL read_cipo got=%h want=a5", rd); end
    checks++; if (regs !== model_vec()) begin failures++; $display("FAIL read_regs got=%h want=%h", regs, model_vec()); end
    checks++; if (strobe_cycles - s0 !== 0) begin failures++; $display("FAIL read_strobe got=%0d want=0", strobe_cycles - s0); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd;
    int s0 = strobe_cycles;
    int e0 = err_cycles;
    run_frame(16'h89FF, 16, 1'b1, 8, rd);
    model_frame(16'h89FF, 16);
    checks++; if (regs !== model_vec()) begin failures++; $display("FAIL oor_regs got=%h want=%h", regs, model_vec()); end
    checks++; if (strobe_cycles - s0 !== 0) begin failures++; $display("FAIL oor_strobe got=%0d want=0", strobe_cycles - s0); end
    checks++; if (err_cycles - e0 !== 0) begin failures++; $display("FAIL oor_err got=%0d want=0", err_cycles - e0); end
    run_frame(16'h0900, 16, 1'b1, 8, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL oor_read got=%h want=00", rd); end
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    int s0 = strobe_cycles;
    int e0 = err_cycles;
    run_frame(16'h83C3, 10, 1'b1, 8, rd);
    model_frame(16'h83C3, 10);
    checks++; if (err_cycles - e0 !== 1) begin failures++; $display("FAIL abort_err got=%0d want=1", err_cycles - e0); end
    checks++; if (regs !== model_vec()) begin failures++; $display("FAIL abort_regs got=%h want=%h", regs, model_vec()); end
    checks++; if (strobe_cycles - s0 !== 0) begin failures++; $display("FAIL abort_strobe got=%0d want=0", strobe_cycles - s0); end
    run_frame(16'h8311, 16, 1'b1, 8, rd);
    model_frame(16'h8311, 16);
    checks++; if (regs[3*DW +: DW] !== 8'h11) begin failures++; $display("FAIL abort_next_reg3 got=%h want=11", regs[3*DW +: DW]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    int s0 = strobe_cycles;
    run_frame(16'h8144, 20, 1'b1, 4, rd);
    model_frame(16'h8144, 20);
    checks++; if (regs[1*DW +: DW] !== 8'h44) begin failures++; $display("FAIL overrun_reg1 got=%h want=44", regs[1*DW +: DW]); end
    checks++; if (strobe_cycles - s0 !== 1) begin failures++; $display("FAIL overrun_strobe got=%0d want=1", strobe_cycles - s0); end
    run_frame(16'h8422, 16, 1'b1, 8, rd);
    model_frame(16'h8422, 16);
    checks++; if (regs[4*DW +: DW] !== 8'h22) begin failures++; $display("FAIL b2b_reg4 got=%h want=22", regs[4*DW +: DW]); end
    checks++; if (regs !== model_vec()) begin failures++; $display("FAIL b2b_regs got=%h want=%h", regs, model_vec()); end
    checks++; if (multi_strobe !== 0) begin failures++; $display("FAIL strobe_onehot got=%0d want=0", multi_strobe); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rd;
    logic [15:0] w;
    int s0 = strobe_cycles;
    run_frame(16'h8077, 12, 1'b0, 0, rd);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NR; k++) exp_regs[k] = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (regs !== model_vec()) begin failures++; $display("FAIL rstmid_regs got=%h want=%h", regs, model_vec()); end
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (strobe_cycles - s0 !== 0) begin failures++; $display("FAIL rstmid_strobe got=%0d want=0", strobe_cycles - s0); end
    w = {1'b1, 7'd0, 8'($urandom)};
    run_frame(w, 16, 1'b1, 8, rd);
    model_frame(w, 16);
    checks++; if (regs !== model_vec()) begin failures++; $display("FAIL rstmid_next_regs got=%h want=%h", regs, model_vec()); end
  endtask

  task automatic test_random();
    logic [7:0]  rd;
    logic [15:0] w;
    int addr;
    bit wr;
    int s0;
    for (int n = 0; n < 16; n++) begin
      half = $urandom_range(4, 7);
      wr   = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 7);
      w    = {wr, 7'(addr), 8'($urandom)};
      s0   = strobe_cycles;
      run_frame(w, 16, 1'b1, 6, rd);
      if (!wr) begin
        checks++; if (rd !== model_read(addr)) begin failures++; $display("FAIL rand_read[%0d] addr=%0d got=%h want=%h", n, addr, rd, model_read(addr)); end
      end
      model_frame(w, 16);
      checks++; if (regs !== model_vec()) begin failures++; $display("FAIL rand_regs[%0d] got=%h want=%h", n, regs, model_vec()); end
      checks++; if (strobe_cycles - s0 !== ((wr && addr < NR) ? 1 : 0)) begin failures++; $display("FAIL rand_strobe[%0d] got=%0d want=%0d", n, strobe_cycles - s0, (wr && addr < NR) ? 1 : 0); end
    end
    half = 5;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
